// File: rtl/algo_err_pkg.sv
// Shared error-report types and helpers for the scrub and ECC-report blocks.
// Holds the log-entry layout and a width-generic saturating increment.
package algo_err_pkg;

  localparam int ERR_BITPADR = 5;

  typedef struct packed {
    logic                   derr;
    logic [ERR_BITPADR-1:0] padr;
  } err_log_t;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] top;
    top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/algo_sync_fifo.sv
// Synchronous FIFO with push/pop, full/empty and a registered head.
// Head reads as zero while empty so it never exposes stale entries.
module algo_sync_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int BITD  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [BITD-1:0]  wr;
  logic [BITD-1:0]  rd;
  logic [BITD:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (BITD+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop)  rd <= rd + 1'b1;
      cnt <= cnt + (BITD+1)'(do_push)
                 - (BITD+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end

endmodule

// File: rtl/algo_1rw_err_logger.sv
// Read-response monitor for the 1RW memory model: checks latency,
// counts single/double errors and logs errored addresses in a FIFO.
module algo_1rw_err_logger
  import algo_err_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int BITPADR   = 5,
  parameter int MEM_DELAY = 1,
  parameter int LOGDEPTH  = 4,
  parameter int BITLOG    = 2,
  parameter int BITCNT    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_0,
  input  logic               read_vld_0,
  input  logic [WIDTH-1:0]   dout_0,
  input  logic               read_serr_0,
  input  logic               read_derr_0,
  input  logic [BITPADR-1:0] read_padr_0,
  input  logic               clr,
  output logic               log_vld,
  input  logic               log_rdy,
  output logic [BITPADR-1:0] log_padr,
  output logic               log_derr,
  output logic               log_ovf,
  output logic [BITCNT-1:0]  serr_cnt,
  output logic [BITCNT-1:0]  derr_cnt,
  output logic               seq_err
);

  localparam int WBITS = $clog2(MEM_DELAY + 1);

  logic [MEM_DELAY-1:0] exp;
  logic [WBITS-1:0]     warm;
  logic                 chk;
  logic                 evt_s;
  logic                 evt_d;
  logic                 evt;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [BITPADR:0]     head;
  logic                 unused_dout;

  assign unused_dout = ^dout_0;

  assign evt_s = read_vld_0 & read_serr_0 & ~read_derr_0;
  assign evt_d = read_vld_0 & read_derr_0;
  assign evt   = evt_s | evt_d;
  assign chk   = (warm == WBITS'(MEM_DELAY));

  assign log_vld = ~empty;
  assign pop     = log_vld & log_rdy;
  assign {log_derr, log_padr} = head;

  algo_sync_fifo #(
    .WIDTH (BITPADR + 1),
    .DEPTH (LOGDEPTH),
    .BITD  (BITLOG)
  ) u_log (
    .clk   (clk),
    .rst   (rst),
    .push  (evt),
    .din   ({read_derr_0, read_padr_0}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      exp      <= '0;
      warm     <= '0;
      serr_cnt <= '0;
      derr_cnt <= '0;
      log_ovf  <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      exp[0] <= read_0;
      for (int i = 1; i < MEM_DELAY; i++)
        exp[i] <= exp[i-1];
      if (!chk) warm <= warm + 1'b1;
      // Clear beats any same-cycle increment or sticky set.
      if (clr) begin
        serr_cnt <= '0;
        derr_cnt <= '0;
        log_ovf  <= 1'b0;
        seq_err  <= 1'b0;
      end else begin
        if (evt_s)
          serr_cnt <= BITCNT'(sat_inc(32'(serr_cnt), BITCNT));
        if (evt_d)
          derr_cnt <= BITCNT'(sat_inc(32'(derr_cnt), BITCNT));
        if (evt & full & ~pop)
          log_ovf <= 1'b1;
        if (chk & (exp[MEM_DELAY-1] != read_vld_0))
          seq_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_algo_1rw_err_logger.sv
// Self-checking bench for algo_1rw_err_logger (MEM_DELAY=2, BITCNT=2).
// Reference model tracks response due-times and a bounded log queue.
module tb_algo_1rw_err_logger;

  localparam int MD   = 2;
  localparam int BC   = 2;
  localparam int DEP  = 4;
  localparam int CMAX = (1 << BC) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       read_0 = 1'b0;
  logic       read_vld_0 = 1'b0;
  logic [3:0] dout_0 = '0;
  logic       read_serr_0 = 1'b0;
  logic       read_derr_0 = 1'b0;
  logic [4:0] read_padr_0 = '0;
  logic       clr = 1'b0;
  logic       log_rdy = 1'b0;
  logic       log_vld;
  logic [4:0] log_padr;
  logic       log_derr;
  logic       log_ovf;
  logic [1:0] serr_cnt;
  logic [1:0] derr_cnt;
  logic       seq_err;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  int         since = 0;
  int         pend[$];
  logic [5:0] mlog[$];
  int         m_serr = 0;
  int         m_derr = 0;
  bit         m_ovf = 0;
  bit         m_seq = 0;

  algo_1rw_err_logger #(
    .WIDTH     (4),
    .BITPADR   (5),
    .MEM_DELAY (MD),
    .LOGDEPTH  (DEP),
    .BITLOG    (2),
    .BITCNT    (BC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .read_0      (read_0),
    .read_vld_0  (read_vld_0),
    .dout_0      (dout_0),
    .read_serr_0 (read_serr_0),
    .read_derr_0 (read_derr_0),
    .read_padr_0 (read_padr_0),
    .clr         (clr),
    .log_vld     (log_vld),
    .log_rdy     (log_rdy),
    .log_padr    (log_padr),
    .log_derr    (log_derr),
    .log_ovf     (log_ovf),
    .serr_cnt    (serr_cnt),
    .derr_cnt    (derr_cnt),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [12:0] obs();
    logic [5:0] h;
    h = log_vld ? {log_derr, log_padr} : 6'h0;
    return {log_vld, h, log_ovf, serr_cnt,
            derr_cnt, seq_err};
  endfunction

  function automatic logic [12:0] mdl();
    logic [5:0] h;
    h = (mlog.size() > 0) ? mlog[0] : 6'h0;
    return {mlog.size() > 0, h, m_ovf,
            2'(m_serr), 2'(m_derr), m_seq};
  endfunction

  function automatic bit due_now();
    foreach (pend[i])
      if (pend[i] == cyc) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit ev;
    bit expv;
    bit drop;
    if (rst) begin
      pend.delete();
      mlog.delete();
      m_serr = 0;
      m_derr = 0;
      m_ovf  = 0;
      m_seq  = 0;
      since  = 0;
    end else begin
      expv = 0;
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i] == cyc) begin
          expv = 1;
          pend.delete(i);
        end
      ev = read_vld_0 && (read_serr_0 || read_derr_0);
      if (mlog.size() > 0 && log_rdy)
        void'(mlog.pop_front());
      drop = 0;
      if (ev) begin
        if (mlog.size() < DEP)
          mlog.push_back({read_derr_0, read_padr_0});
        else
          drop = 1;
      end
      if (clr) begin
        m_serr = 0;
        m_derr = 0;
        m_ovf  = 0;
        m_seq  = 0;
      end else begin
        if (ev && read_derr_0)
          m_derr = (m_derr < CMAX) ? m_derr + 1 : CMAX;
        else if (ev)
          m_serr = (m_serr < CMAX) ? m_serr + 1 : CMAX;
        if (drop) m_ovf = 1;
        if (since >= MD && expv != read_vld_0)
          m_seq = 1;
      end
      if (read_0) pend.push_back(cyc + MD);
      since++;
    end
    cyc++;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(
    input logic       rd,
    input logic       vld,
    input logic       se,
    input logic       de,
    input logic [4:0] pa,
    input logic       c,
    input logic       rdy
  );
    read_0      = rd;
    read_vld_0  = vld;
    read_serr_0 = se;
    read_derr_0 = de;
    read_padr_0 = pa;
    dout_0      = 4'($urandom);
    clr         = c;
    log_rdy     = rdy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== 13'h0) begin
        errors++;
        $display("FAIL reset_outputs got=%h want=0", obs());
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== mdl()) begin
        errors++;
        $display("FAIL reset_idle got=%h want=%h",
                 obs(), mdl());
      end
    end
  endtask

  task automatic test_seq();
    bit rd;
    bit vl;
    for (int t = 0; t < 12; t++) begin
      rd = (t == 3 || t == 4 || t == 7);
      vl = (t == 5 || t == 6 || t == 9 || t == 10);
      set_in(rd, vl, 0, 0, 0, 0, 0);
      step();
      checks++;
      if (seq_err !== (t >= 10)) begin
        errors++;
        $display("FAIL seq_err t=%0d got=%b want=%b",
                 t, seq_err, t >= 10);
      end
      checks++;
      if (obs() !== mdl()) begin
        errors++;
        $display("FAIL seq_model t=%0d got=%h want=%h",
                 t, obs(), mdl());
      end
    end
    set_in(0, 0, 0, 0, 0, 1, 0);
    step();
    checks++;
    if (seq_err !== 1'b0) begin
      errors++;
      $display("FAIL seq_clr got=%b want=0", seq_err);
    end
  endtask

  task automatic test_classify();
    set_in(1, 0, 0, 0, 0, 0, 0); step();
    set_in(1, 0, 0, 0, 0, 0, 0); step();
    set_in(1, 1, 1, 0, 5'h03, 0, 0); step();
    set_in(0, 1, 1, 1, 5'h11, 0, 0); step();
    set_in(0, 1, 0, 0, 5'h1a, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0); step();
    checks++;
    if (serr_cnt !== 2'd1 || derr_cnt !== 2'd1) begin
      errors++;
      $display("FAIL cls_cnt got=%0d/%0d want=1/1",
               serr_cnt, derr_cnt);
    end
    checks++;
    if ({log_vld, log_derr, log_padr} !== 7'h43) begin
      errors++;
      $display("FAIL cls_head0 got=%h want=43",
               {log_vld, log_derr, log_padr});
    end
    set_in(0, 0, 0, 0, 0, 0, 1); step();
    checks++;
    if ({log_vld, log_derr, log_padr} !== 7'h71) begin
      errors++;
      $display("FAIL cls_head1 got=%h want=71",
               {log_vld, log_derr, log_padr});
    end
    step();
    checks++;
    if (log_vld !== 1'b0 || obs() !== mdl()) begin
      errors++;
      $display("FAIL cls_empty got=%h want=%h",
               obs(), mdl());
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_overflow();
    set_in(0, 0, 0, 0, 0, 1, 0); step();
    for (int t = 0; t < 7; t++) begin
      set_in(t < 5, t >= 2, t >= 2, 0,
             5'(8 + t - 2), 0, 0);
      step();
      if (t == 5) begin
        checks++;
        if (log_ovf !== 1'b0) begin
          errors++;
          $display("FAIL ovf_early got=%b want=0", log_ovf);
        end
      end
    end
    checks++;
    if (log_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got=%b want=1", log_ovf);
    end
    set_in(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({log_vld, log_derr, log_padr} !==
          7'(7'h40 | (8 + k))) begin
        errors++;
        $display("FAIL ovf_drain k=%0d got=%h want=%h", k,
                 {log_vld, log_derr, log_padr},
                 7'(7'h40 | (8 + k)));
      end
      step();
    end
    checks++;
    if (log_vld !== 1'b0) begin
      errors++;
      $display("FAIL ovf_5th got=%b want=0", log_vld);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [4:0] want[4];
    want = '{5'h11, 5'h12, 5'h13, 5'h1f};
    set_in(0, 0, 0, 0, 0, 1, 0); step();
    for (int t = 0; t < 7; t++) begin
      set_in(t < 5, t >= 2, 0, t >= 2,
             (t == 6) ? 5'h1f : 5'(5'h10 + t - 2),
             0, t == 6);
      step();
    end
    checks++;
    if (log_ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ovf got=%b want=0", log_ovf);
    end
    set_in(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({log_vld, log_derr, log_padr} !==
          {2'b11, want[k]}) begin
        errors++;
        $display("FAIL b2b_drain k=%0d got=%h want=%h", k,
                 {log_vld, log_derr, log_padr},
                 {2'b11, want[k]});
      end
      step();
    end
    checks++;
    if (log_vld !== 1'b0 || obs() !== mdl()) begin
      errors++;
      $display("FAIL b2b_empty got=%h want=%h",
               obs(), mdl());
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_saturate();
    set_in(0, 0, 0, 0, 0, 1, 1); step();
    for (int t = 0; t < 8; t++) begin
      set_in(t < 6, t >= 2, t >= 2, 0,
             5'($urandom), t == 7, 0);
      step();
      if (t == 6) begin
        checks++;
        if (serr_cnt !== 2'd3) begin
          errors++;
          $display("FAIL sat_cnt got=%0d want=3", serr_cnt);
        end
      end
    end
    checks++;
    if (serr_cnt !== 2'd0 || obs() !== mdl()) begin
      errors++;
      $display("FAIL sat_clr got=%h want=%h",
               obs(), mdl());
    end
    set_in(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step();
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_rst_mid();
    set_in(1, 1, 1, 0, 5'h05, 0, 0); step();
    set_in(1, 0, 0, 0, 0, 0, 0); step();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs() !== 13'h0) begin
        errors++;
        $display("FAIL rst_mid got=%h want=0", obs());
      end
    end
    rst = 1'b0;
    step();
    set_in(0, 1, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (seq_err !== 1'b0 || obs() !== mdl()) begin
        errors++;
        $display("FAIL rst_mask got=%h want=%h",
                 obs(), mdl());
      end
      step();
    end
  endtask

  task automatic test_random();
    bit v;
    for (int i = 0; i < 400; i++) begin
      v = due_now() ^ ($urandom_range(49) == 0);
      rst = ($urandom_range(149) == 0);
      set_in($urandom_range(1), v,
             $urandom_range(3) == 0,
             $urandom_range(3) == 0,
             5'($urandom),
             $urandom_range(39) == 0,
             $urandom_range(2) != 0);
      step();
      checks++;
      if (obs() !== mdl()) begin
        errors++;
        $display("FAIL random i=%0d got=%h want=%h",
                 i, obs(), mdl());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_seq();
    test_classify();
    test_overflow();
    test_back_to_back();
    test_saturate();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
